// File: rtl/mlaccel_spi_cmd_if.sv
// mlaccel_spi_cmd_if
//   Byte-stream link between the SPI slave and the command decoder.
//   din_*  : received bytes, one-cycle strobes from the SPI slave.
//            din_start qualifies din_valid and marks an opcode byte.
//   dout_* : transmit bytes back to the SPI slave.
//
//   Handshake: the decoder raises dout_valid with dout_data and holds both
//   stable until a cycle where dout_valid && dout_ready; that cycle is the
//   transfer. din_* has no back-pressure; a byte exists only while
//   din_valid is high.
//
//   master : the SPI slave side (drives din_*, dout_ready)
//   slave  : the command decoder side (drives dout_valid, dout_data)
interface mlaccel_spi_cmd_if;
   logic       din_valid;
   logic       din_start;
   logic [7:0] din_data;
   logic       dout_valid;
   logic       dout_ready;
   logic [7:0] dout_data;

   modport master (
      output din_valid, din_start, din_data, dout_ready,
      input  dout_valid, dout_data
   );

   modport slave (
      input  din_valid, din_start, din_data, dout_ready,
      output dout_valid, dout_data
   );
endinterface

// File: rtl/mlaccel_spi_cmd.sv
// mlaccel_spi_cmd
//   Parses one command per chip-select transaction from the SPI byte
//   stream and drives a byte-wide memory port and an accelerator start
//   strobe. Read data and status bytes go back over spi.dout_*.
//
//   Opcodes: 0x20 STATUS, 0x21 WRITE, 0x22 READ, 0x24 RUN; any other
//   opcode sets the sticky cmd_err flag and ignores the transaction.
//
// Ports
//   clock, reset : single clock, synchronous active-high reset
//   active       : chip select (already synchronised); low forces IDLE
//   spi          : byte stream link (slave modport)
//   mem_addr     : memory address (ADDR_W bits)
//   mem_wdata    : write data
//   mem_wen      : one-cycle write strobe per written byte
//   mem_ren      : read strobe; mem_rdata valid the following cycle
//   mem_rdata    : memory read data
//   busy         : accelerator busy, reported in the status byte
//   run_start    : one-cycle accelerator start pulse
//   cmd_err      : sticky unknown-opcode flag, cleared by a STATUS read
//   dbg_state    : current FSM state
//
// All outputs are registered.
module mlaccel_spi_cmd #(
   parameter int ADDR_W = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              active,
   mlaccel_spi_cmd_if.slave  spi,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              mem_wen,
   output logic              mem_ren,
   input  logic [7:0]        mem_rdata,
   input  logic              busy,
   output logic              run_start,
   output logic              cmd_err,
   output logic [3:0]        dbg_state
);

   typedef enum logic [3:0] {
      IDLE, ADDR_HI, ADDR_LO, WRITE, RD_FETCH, RD_WAIT, RD_HOLD, ST_HOLD, IGNORE
   } state_t;

   state_t            state_q, state_n;
   logic [ADDR_W-1:0] addr_q, addr_n;
   logic              rd_mode_q, rd_mode_n;
   logic              dout_valid_q, dout_valid_n;
   logic [7:0]        dout_data_q, dout_data_n;
   logic [ADDR_W-1:0] mem_addr_n;
   logic [7:0]        mem_wdata_n;
   logic              mem_wen_n, mem_ren_n, run_start_n, cmd_err_n;

   logic              byte_in, opcode_in, handshake;
   logic [ADDR_W-1:0] addr_inc, addr_lo;

   assign byte_in   = spi.din_valid && !spi.din_start;
   assign opcode_in = spi.din_valid &&  spi.din_start;
   assign handshake = dout_valid_q && spi.dout_ready;
   // Natural ADDR_W-bit overflow gives the wrap to 0.
   assign addr_inc  = addr_q + ADDR_W'(1);
   assign addr_lo   = {addr_q[ADDR_W-1:8], spi.din_data};

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         rd_mode_q    <= 1'b0;
         dout_valid_q <= 1'b0;
         dout_data_q  <= 8'h00;
         mem_addr     <= '0;
         mem_wdata    <= 8'h00;
         mem_wen      <= 1'b0;
         mem_ren      <= 1'b0;
         run_start    <= 1'b0;
         cmd_err      <= 1'b0;
      end else begin
         state_q      <= state_n;
         addr_q       <= addr_n;
         rd_mode_q    <= rd_mode_n;
         dout_valid_q <= dout_valid_n;
         dout_data_q  <= dout_data_n;
         mem_addr     <= mem_addr_n;
         mem_wdata    <= mem_wdata_n;
         mem_wen      <= mem_wen_n;
         mem_ren      <= mem_ren_n;
         run_start    <= run_start_n;
         cmd_err      <= cmd_err_n;
      end
   end

   always_comb begin
      state_n      = state_q;
      addr_n       = addr_q;
      rd_mode_n    = rd_mode_q;
      dout_valid_n = dout_valid_q;
      dout_data_n  = dout_data_q;
      mem_addr_n   = mem_addr;
      mem_wdata_n  = mem_wdata;
      mem_wen_n    = 1'b0;
      mem_ren_n    = 1'b0;
      run_start_n  = 1'b0;
      cmd_err_n    = cmd_err;

      if (!active) begin
         // Chip select low beats any byte in the same cycle.
         state_n      = IDLE;
         dout_valid_n = 1'b0;
      end else if (opcode_in) begin
         // A new opcode restarts decoding from any state and drops any
         // pending transmit byte, even one being handshaken this cycle.
         dout_valid_n = 1'b0;
         case (spi.din_data)
            8'h20: begin
               state_n      = ST_HOLD;
               dout_valid_n = 1'b1;
               dout_data_n  = {busy, 5'b0, 1'b0, cmd_err};
            end
            8'h21: begin
               state_n   = ADDR_HI;
               rd_mode_n = 1'b0;
            end
            8'h22: begin
               state_n   = ADDR_HI;
               rd_mode_n = 1'b1;
            end
            8'h24: begin
               state_n     = IGNORE;
               run_start_n = 1'b1;
            end
            default: begin
               state_n   = IGNORE;
               cmd_err_n = 1'b1;
            end
         endcase
      end else begin
         case (state_q)
            ADDR_HI: if (byte_in) begin
               addr_n  = {spi.din_data[ADDR_W-9:0], addr_q[7:0]};
               state_n = ADDR_LO;
            end
            ADDR_LO: if (byte_in) begin
               addr_n = addr_lo;
               if (rd_mode_q) begin
                  // The read strobe is registered here so it is already
                  // high during the RD_FETCH cycle.
                  mem_ren_n  = 1'b1;
                  mem_addr_n = addr_lo;
                  state_n    = RD_FETCH;
               end else begin
                  state_n = WRITE;
               end
            end
            WRITE: if (byte_in) begin
               mem_wen_n   = 1'b1;
               mem_addr_n  = addr_q;
               mem_wdata_n = spi.din_data;
               addr_n      = addr_inc;
            end
            RD_FETCH: state_n = RD_WAIT;
            RD_WAIT: begin
               dout_data_n  = mem_rdata;
               dout_valid_n = 1'b1;
               state_n      = RD_HOLD;
            end
            RD_HOLD: if (handshake) begin
               dout_valid_n = 1'b0;
               addr_n       = addr_inc;
               mem_ren_n    = 1'b1;
               mem_addr_n   = addr_inc;
               state_n      = RD_FETCH;
            end
            ST_HOLD: if (handshake) begin
               dout_valid_n = 1'b0;
               cmd_err_n    = 1'b0;
               state_n      = IGNORE;
            end
            default: state_n = state_q;  // IDLE / IGNORE discard data bytes
         endcase
      end
   end

   assign spi.dout_valid = dout_valid_q;
   assign spi.dout_data  = dout_data_q;
   assign dbg_state      = state_q;

endmodule

// File: doc/mlaccel_spi_cmd.md
# mlaccel_spi_cmd

Command decoder directly downstream of the SPI slave byte interface. Consumes the received byte stream (`din_*`), parses one command per chip-select transaction, and drives a byte-wide memory port and a run-start strobe. It returns read data and status bytes to the SPI slave over the `dout_*` valid/ready handshake.

## Interface
- `ADDR_W`, default 16: memory address width, legal range 9..16.
  - The address is formed from two received bytes (hi, lo); only the low `ADDR_W` bits are used.
- `clock` in, 1: single clock for all logic.
- `reset` in, 1: synchronous, active-high.
- `active` in, 1: chip select active, already synchronised by the SPI slave.
- `din_valid` in, 1: received-byte strobe; one cycle per byte.
- `din_start` in, 1: qualifies `din_valid`; marks the first byte of a transaction (the opcode).
- `din_data` in, 8: received byte.
- `dout_valid` out, 1: transmit byte available.
- `dout_ready` in, 1: the SPI slave accepts the byte when `dout_valid && dout_ready`.
- `dout_data` out, 8: transmit byte.
- `mem_addr` out, `ADDR_W`: memory address.
- `mem_wdata` out, 8: write data.
- `mem_wen` out, 1: write strobe, one cycle per byte.
- `mem_ren` out, 1: read strobe; `mem_rdata` is valid in the following cycle.
- `mem_rdata` in, 8: read data.
- `busy` in, 1: accelerator busy; reported in the status byte.
- `run_start` out, 1: one-cycle accelerator start pulse.
- `cmd_err` out, 1: sticky error flag (unknown opcode).

## Operation
- Opcodes (first byte, `din_start`=1):
  - 0x20 STATUS
  - 0x21 WRITE
  - 0x22 READ
  - 0x24 RUN
  - anything else: set `cmd_err`, enter IGNORE.
- States: IDLE, ADDR_HI, ADDR_LO, WRITE, RD_FETCH, RD_WAIT, RD_HOLD, ST_HOLD, IGNORE.
- A byte with `din_start`=1 always restarts decoding from the opcode, in any state. Any pending `dout_valid` is dropped.
- WRITE / READ: ADDR_HI captures `addr[15:8]`, ADDR_LO captures `addr[7:0]`.
  - WRITE then enters WRITE state; READ enters RD_FETCH.
- WRITE state: each `din_valid` byte produces `mem_wen`, `mem_addr`=addr, `mem_wdata`=byte. Then addr increments, wrapping 2^`ADDR_W`-1 → 0.
- READ: RD_FETCH issues `mem_ren` → RD_WAIT captures `mem_rdata` into `dout_data` → RD_HOLD with `dout_valid`=1.
  - On handshake: addr increments (same wrap), then back to RD_FETCH. Streaming continues until `active` falls or a new opcode arrives.
  - Bytes received during READ (dummy clocks) after ADDR_LO are ignored.
- STATUS: `dout_data` = {`busy`, 5'b0, 1'b0, `cmd_err`}, sampled when the opcode is received.
  - ST_HOLD holds `dout_valid` until the handshake, then goes to IGNORE.
  - `cmd_err` clears on that handshake.
- RUN: `run_start`=1 for exactly one cycle, then IGNORE. Data bytes that follow are discarded.
- IGNORE discards bytes until the next opcode.
- `active`=0 (sampled each cycle): state → IDLE, `dout_valid` → 0. `cmd_err` is kept.
- Reset: state IDLE; all outputs 0 (`dout_valid`, `dout_data`, `mem_addr`, `mem_wdata`, `mem_wen`, `mem_ren`, `run_start`, `cmd_err`); addr register 0.
  - Reset mid-read or mid-write aborts with no further memory strobes.

## Timing
- All outputs are registered.
- Opcode/address/data byte accepted in cycle N (`din_valid`=1) → effect visible in N+1.
- Write: data byte in cycle N → `mem_wen`=1 in cycle N+1 only. Back-to-back bytes produce back-to-back writes.
- Read: ADDR_LO byte in cycle N:
  - `mem_ren`=1 in N+1;
  - `mem_rdata` sampled at the end of N+2;
  - `dout_valid`=1 from N+3.
- Read handshake in cycle M → `dout_valid`=0 in M+1, `mem_ren`=1 in M+1 (addr+1), `dout_valid`=1 again in M+3.
- STATUS opcode in cycle N → `dout_valid`=1 from N+1.
- RUN opcode in cycle N → `run_start`=1 in N+1.
- `dout_data` is stable while `dout_valid`=1. `dout_valid` falls only after the handshake, a new opcode, `active`=0, or reset.
- Simultaneous events:
  - `din_valid`+`din_start` in the same cycle as a handshake: the new opcode wins; addr does not increment.
  - `active` fall and `din_valid` in the same cycle: `active` wins, and the byte is dropped.

## Test plan
- After reset, every output reads 0. Send STATUS with `busy`=1 → `dout_data`=0x80, `dout_valid` in cycle N+1.
- WRITE to 0x0102 with data AA, BB, CC → `mem_wen` pulses at addr 0x0102/0x0103/0x0104 with AA/BB/CC, one cycle after each byte.
- READ at 0xFFFE (`ADDR_W`=16) with memory returning 11, 22, 33 → `dout_data` 11, 22, 33 at addr FFFE, FFFF, 0000; `dout_valid` holds while `dout_ready`=0.
- Opcode 0x55 → `cmd_err`=1; a following STATUS returns 0x01; after its handshake `cmd_err`=0.
- RUN followed by two data bytes → exactly one `run_start` pulse, no memory strobes.
- Streaming READ: drop `active` → `dout_valid`=0 next cycle with no further `mem_ren`. Repeat with `reset` asserted mid-WRITE → no `mem_wen` after reset.
